// File: rtl/multi_button_fsm.sv
// multi_button_fsm: N_CH independent pushbutton channels. Each channel has a
// two-flop synchroniser, a four-state debounce FSM with press/release
// pulses, and a registered output in toggle or momentary mode.
// Optional feature macro: LONG_PRESS_EN (adds long_press output and a hold
// counter that flags a press held for LONG_CYCLES cycles).
module multi_button_fsm #(
    parameter int N_CH            = 4,
    parameter int DEBOUNCE_CYCLES = 3,
    parameter int CNT_W           = 16,
    parameter int LONG_CYCLES     = 50
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] button,
    input  logic [N_CH-1:0] mode,
    input  logic            clear,
    output logic [N_CH-1:0] stateful_button,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] release_pulse
`ifdef LONG_PRESS_EN
    ,
    output logic [N_CH-1:0] long_press
`endif
);

    typedef enum logic [1:0] {
        S_LOW   = 2'd0,
        S_ARM_H = 2'd1,
        S_HIGH  = 2'd2,
        S_ARM_L = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [N_CH-1:0]  sync1_r;
    logic [N_CH-1:0]  sync2_r;      // btn_s: the only copy used downstream
    state_t           state_r [N_CH];
    logic [CNT_W-1:0] cnt_r   [N_CH];
    logic [N_CH-1:0]  stable_r;

    logic [N_CH-1:0]  press_acc_s;
    logic [N_CH-1:0]  rel_acc_s;
    logic [N_CH-1:0]  stable_nxt_s;
    logic [N_CH-1:0]  long_acc_s;
    logic [N_CH-1:0]  out_nxt_s;

    // Two-flop synchroniser for the raw asynchronous button levels
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= '0;
            sync2_r <= '0;
        end else begin
            sync1_r <= button;
            sync2_r <= sync1_r;
        end
    end

    // Acceptance of a level change in this cycle and the resulting stable level
    always_comb begin
        press_acc_s  = '0;
        rel_acc_s    = '0;
        stable_nxt_s = stable_r;
        for (int i = 0; i < N_CH; i++) begin
            press_acc_s[i] = (state_r[i] == S_ARM_H) && sync2_r[i] && (cnt_r[i] == CNT_LAST);
            rel_acc_s[i]   = (state_r[i] == S_ARM_L) && !sync2_r[i] && (cnt_r[i] == CNT_LAST);
            if (press_acc_s[i]) begin
                stable_nxt_s[i] = 1'b1;
            end else if (rel_acc_s[i]) begin
                stable_nxt_s[i] = 1'b0;
            end else begin
                stable_nxt_s[i] = stable_r[i];
            end
        end
    end

    // Next output value: momentary follows stable; toggle flips on press,
    // with clear and long press both forcing the toggle state low
    always_comb begin
        out_nxt_s = stateful_button;
        for (int i = 0; i < N_CH; i++) begin
            if (mode[i]) begin
                out_nxt_s[i] = stable_nxt_s[i];
            end else if (clear || long_acc_s[i]) begin
                out_nxt_s[i] = 1'b0;
            end else if (press_acc_s[i]) begin
                out_nxt_s[i] = ~stateful_button[i];
            end else begin
                out_nxt_s[i] = stateful_button[i];
            end
        end
    end

    // Per-channel debounce FSM with registered pulses and output state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                state_r[i] <= S_LOW;
                cnt_r[i]   <= '0;
            end
            stable_r        <= '0;
            press_pulse     <= '0;
            release_pulse   <= '0;
            stateful_button <= '0;
        end else begin
            stable_r        <= stable_nxt_s;
            press_pulse     <= press_acc_s;
            release_pulse   <= rel_acc_s;
            stateful_button <= out_nxt_s;
            for (int i = 0; i < N_CH; i++) begin
                case (state_r[i])
                    S_LOW: begin
                        if (sync2_r[i]) begin
                            state_r[i] <= S_ARM_H;
                            cnt_r[i]   <= CNT_ONE;
                        end else begin
                            state_r[i] <= S_LOW;
                            cnt_r[i]   <= '0;
                        end
                    end
                    S_ARM_H: begin
                        if (!sync2_r[i]) begin
                            state_r[i] <= S_LOW;
                            cnt_r[i]   <= '0;
                        end else if (cnt_r[i] == CNT_LAST) begin
                            state_r[i] <= S_HIGH;
                            cnt_r[i]   <= '0;
                        end else begin
                            state_r[i] <= S_ARM_H;
                            // saturating increment; CNT_LAST is hit first anyway
                            cnt_r[i]   <= (cnt_r[i] == CNT_MAX) ? cnt_r[i] : cnt_r[i] + CNT_ONE;
                        end
                    end
                    S_HIGH: begin
                        if (!sync2_r[i]) begin
                            state_r[i] <= S_ARM_L;
                            cnt_r[i]   <= CNT_ONE;
                        end else begin
                            state_r[i] <= S_HIGH;
                            cnt_r[i]   <= '0;
                        end
                    end
                    S_ARM_L: begin
                        if (sync2_r[i]) begin
                            state_r[i] <= S_HIGH;
                            cnt_r[i]   <= '0;
                        end else if (cnt_r[i] == CNT_LAST) begin
                            state_r[i] <= S_LOW;
                            cnt_r[i]   <= '0;
                        end else begin
                            state_r[i] <= S_ARM_L;
                            cnt_r[i]   <= (cnt_r[i] == CNT_MAX) ? cnt_r[i] : cnt_r[i] + CNT_ONE;
                        end
                    end
                    default: begin
                        state_r[i] <= S_LOW;
                        cnt_r[i]   <= '0;
                    end
                endcase
            end
        end
    end

`ifdef LONG_PRESS_EN
    localparam int               HOLD_W    = $clog2(LONG_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    logic [HOLD_W-1:0] hold_r [N_CH];
    logic [N_CH-1:0]   long_done_r;   // one long press per press, even across release bounce

    // Long-press fires on the cycle the hold count reaches LONG_CYCLES
    always_comb begin
        long_acc_s = '0;
        for (int i = 0; i < N_CH; i++) begin
            long_acc_s[i] = (state_r[i] == S_HIGH) && !long_done_r[i] && (hold_r[i] == HOLD_LAST);
        end
    end

    // Hold counter runs only in S_HIGH; done flag clears once fully released
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                hold_r[i] <= '0;
            end
            long_done_r <= '0;
            long_press  <= '0;
        end else begin
            long_press <= long_acc_s;
            for (int i = 0; i < N_CH; i++) begin
                if (state_r[i] == S_HIGH) begin
                    hold_r[i] <= (hold_r[i] == HOLD_LAST) ? hold_r[i] : hold_r[i] + HOLD_ONE;
                end else begin
                    hold_r[i] <= '0;
                end
                if (long_acc_s[i]) begin
                    long_done_r[i] <= 1'b1;
                end else if (state_r[i] == S_LOW) begin
                    long_done_r[i] <= 1'b0;
                end else begin
                    long_done_r[i] <= long_done_r[i];
                end
            end
        end
    end
`else
    assign long_acc_s = '0;
`endif

endmodule

// File: tb/tb_multi_button_fsm.sv
// Directed self-checking bench for multi_button_fsm (default parameters).
// Build with +define+LONG_PRESS_EN to also exercise the long-press feature.
module tb_multi_button_fsm;

    logic       clk;
    logic       rst_n;
    logic [3:0] button;
    logic [3:0] mode;
    logic       clear;
    logic [3:0] stateful_button;
    logic [3:0] press_pulse;
    logic [3:0] release_pulse;
`ifdef LONG_PRESS_EN
    logic [3:0] long_press;
`endif

    int checks   = 0;
    int failures = 0;
    int np;
    int nr;

    multi_button_fsm dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .button          (button),
        .mode            (mode),
        .clear           (clear),
        .stateful_button (stateful_button),
        .press_pulse     (press_pulse),
        .release_pulse   (release_pulse)
`ifdef LONG_PRESS_EN
        ,
        .long_press      (long_press)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Count press/release pulses on one channel over n cycles (sampled on negedge)
    task automatic count_pulses(input int n, input int ch, output int p, output int r);
        p = 0;
        r = 0;
        repeat (n) begin
            @(negedge clk);
            p += int'(press_pulse[ch]);
            r += int'(release_pulse[ch]);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        button = 4'hF;
        mode   = 4'h0;
        clear  = 1'b0;

        // reset state with buttons held
        repeat (3) @(negedge clk);
        check_val("rst_state", 32'(stateful_button), 32'h0);
        check_val("rst_press", 32'(press_pulse), 32'h0);
        check_val("rst_release", 32'(release_pulse), 32'h0);

        // held buttons register 2+DEBOUNCE edges after reset release
        rst_n = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            check_val($sformatf("rst_lat_press_%0d", i), 32'(press_pulse), (i == 5) ? 32'hF : 32'h0);
        end
        check_val("rst_lat_state", 32'(stateful_button), 32'hF);

        button = 4'h0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            check_val($sformatf("rel_all_%0d", i), 32'(release_pulse), (i == 5) ? 32'hF : 32'h0);
        end
        check_val("rel_keeps_toggle", 32'(stateful_button), 32'hF);

        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check_val("clear_all", 32'(stateful_button), 32'h0);

        // sub-period bounce on ch0, then settle high
        button[0] = 1'b1; #3;
        button[0] = 1'b0; #3;
        button[0] = 1'b1; #3;
        button[0] = 1'b0; #3;
        button[0] = 1'b1; #3;
        button[0] = 1'b0; #3;
        button[0] = 1'b1;
        count_pulses(12, 0, np, nr);
        check_val("bounce_press_cnt", 32'(np), 32'd1);
        check_val("bounce_rel_cnt", 32'(nr), 32'd0);
        check_val("bounce_state", 32'(stateful_button[0]), 32'd1);
        button[0] = 1'b0;
        count_pulses(12, 0, np, nr);
        check_val("bounce_off_rel", 32'(nr), 32'd1);
        check_val("bounce_off_state", 32'(stateful_button[0]), 32'd1);

        // 2-cycle glitch is below the debounce threshold
        button[0] = 1'b1;
        repeat (2) @(negedge clk);
        button[0] = 1'b0;
        count_pulses(10, 0, np, nr);
        check_val("glitch2_press", 32'(np), 32'd0);
        check_val("glitch2_state", 32'(stateful_button[0]), 32'd1);

        // 3-cycle pulse is exactly at the threshold: accepted
        button[0] = 1'b1;
        repeat (3) @(negedge clk);
        button[0] = 1'b0;
        count_pulses(12, 0, np, nr);
        check_val("pulse3_press", 32'(np), 32'd1);
        check_val("pulse3_rel", 32'(nr), 32'd1);
        check_val("pulse3_state", 32'(stateful_button[0]), 32'd0);

        // toggle sequence on ch1
        for (int k = 0; k < 2; k++) begin
            button[1] = 1'b1;
            count_pulses(8, 1, np, nr);
            check_val($sformatf("tog_press_%0d", k), 32'(np), 32'd1);
            check_val($sformatf("tog_state_on_%0d", k), 32'(stateful_button[1]), (k == 0) ? 32'd1 : 32'd0);
            button[1] = 1'b0;
            count_pulses(8, 1, np, nr);
            check_val($sformatf("tog_rel_%0d", k), 32'(nr), 32'd1);
            check_val($sformatf("tog_state_off_%0d", k), 32'(stateful_button[1]), (k == 0) ? 32'd1 : 32'd0);
        end

        // momentary on ch2: output tracks stable, aligned to the pulses
        mode = 4'b0100;
        button[2] = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            check_val($sformatf("mom_on_state_%0d", i), 32'(stateful_button[2]), (i >= 5) ? 32'd1 : 32'd0);
            check_val($sformatf("mom_on_press_%0d", i), 32'(press_pulse[2]), (i == 5) ? 32'd1 : 32'd0);
        end
        button[2] = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            check_val($sformatf("mom_off_state_%0d", i), 32'(stateful_button[2]), (i < 5) ? 32'd1 : 32'd0);
            check_val($sformatf("mom_off_rel_%0d", i), 32'(release_pulse[2]), (i == 5) ? 32'd1 : 32'd0);
        end

        // momentary -> toggle keeps current value; toggle -> momentary follows stable
        button[2] = 1'b1;
        repeat (8) @(negedge clk);
        mode = 4'b0000;
        @(negedge clk);
        check_val("mom2tog_keep", 32'(stateful_button[2]), 32'd1);
        button[2] = 1'b0;
        repeat (8) @(negedge clk);
        check_val("mom2tog_rel", 32'(stateful_button[2]), 32'd1);
        mode = 4'b0100;
        @(negedge clk);
        check_val("tog2mom_follow", 32'(stateful_button[2]), 32'd0);

        // clear does not touch momentary channels
        button[2] = 1'b1;
        repeat (8) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check_val("clear_mom_unaff", 32'(stateful_button[2]), 32'd1);
        button[2] = 1'b0;
        repeat (8) @(negedge clk);
        mode = 4'b0000;

        // clear colliding with an accepted press on ch3
        button[3] = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (i == 4) clear = 1'b1;
        end
        clear = 1'b0;
        check_val("coll_press", 32'(press_pulse[3]), 32'd1);
        check_val("coll_state", 32'(stateful_button[3]), 32'd0);
        @(negedge clk);
        check_val("coll_state_after", 32'(stateful_button[3]), 32'd0);
        check_val("coll_press_after", 32'(press_pulse[3]), 32'd0);
        button[3] = 1'b0;
        repeat (8) @(negedge clk);

`ifdef LONG_PRESS_EN
        // long press on ch0: pulse 50 cycles after press, forces toggle low
        button[0] = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            check_val($sformatf("long_%0d", i), 32'(long_press[0]), (i == 55) ? 32'd1 : 32'd0);
            if (i == 5) check_val("long_state_on", 32'(stateful_button[0]), 32'd1);
        end
        check_val("long_state_end", 32'(stateful_button[0]), 32'd0);
        button[0] = 1'b0;
        repeat (8) @(negedge clk);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multi_button_fsm.md
Name: multi_button_fsm

Overview:
- Parametrised, multi-channel successor to the single-button toggle FSM.
- Per channel: synchronise a raw pushbutton, debounce it with a programmable cycle count, and emit a one-cycle press pulse.
- Per channel, produce a stateful output in toggle mode or momentary mode, selected by the `mode` input.
- Sits between board pushbuttons and the user-logic control registers.

Parameters:
- N_CH, 4, number of independent button channels (1..16).
- DEBOUNCE_CYCLES, 3, consecutive synchronised samples required to accept a level change (2..65535).
- CNT_W, 16, width of each debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- LONG_CYCLES, 50, held-press duration for long-press detection (used only with LONG_PRESS_EN).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- button  input  N_CH  raw asynchronous button levels, bit i = channel i.
- mode  input  N_CH  per-channel mode: 0 = toggle, 1 = momentary.
- clear  input  1  synchronous clear of all toggle states.
- stateful_button  output  N_CH  registered per-channel state output.
- press_pulse  output  N_CH  one-cycle pulse on each accepted press.
- release_pulse  output  N_CH  one-cycle pulse on each accepted release.

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset (`rst_n` = 0, immediate): all outputs, sync flops, counters, stable levels and toggle states are 0; FSMs go to S_LOW.
- Synchroniser: two flops per channel, button -> s1 -> s2. Only s2 (btn_s) is used downstream.
- Per-channel debounce FSM states:
  - S_LOW: stable = 0, cnt = 0. If btn_s = 1, go to S_ARM_H with cnt = 1.
  - S_ARM_H: if btn_s = 0, go to S_LOW with cnt = 0. Else if cnt = DEBOUNCE_CYCLES-1, go to S_HIGH with stable = 1 and press_pulse = 1 for one cycle. Else cnt++.
  - S_HIGH: stable = 1, cnt = 0. If btn_s = 0, go to S_ARM_L with cnt = 1.
  - S_ARM_L: mirror of S_ARM_H. On acceptance go to S_LOW with stable = 0 and release_pulse = 1 for one cycle.
- A glitch shorter than DEBOUNCE_CYCLES synchronised cycles never changes `stable` and never pulses.
- Latency: raw edge first sampled at rising edge k -> press_pulse/release_pulse high after edge k+1+DEBOUNCE_CYCLES (5 edges for the default).
- Toggle mode (mode[i] = 0): stateful_button[i] inverts in the same cycle press_pulse[i] is asserted. Release does not affect it.
- Momentary mode (mode[i] = 1): stateful_button[i] = stable[i], registered, so it changes in the same cycle as the pulses.
- Mode change: `mode` is sampled every cycle.
  - Toggle -> momentary: output follows `stable` from the next edge.
  - Momentary -> toggle: the current output value is retained as the toggle state.
- Clear: `clear` = 1 sets every toggle-mode channel's stateful_button to 0 at the next edge. Momentary channels are unaffected.
  - If clear and a press are accepted in the same cycle, clear wins: output = 0. press_pulse still asserts.
- Channels are fully independent. Simultaneous presses on any subset are each handled in the same cycle.
- Counters saturate and never wrap. DEBOUNCE_CYCLES-1 is always reached before overflow.
- Reset asserted mid-debounce discards the partial count. After release of rst_n, a held button needs 2 + DEBOUNCE_CYCLES edges to register a press.

Optional Feature:
- Macro: LONG_PRESS_EN.
- Defined:
  - Adds output `long_press` (N_CH).
  - Per-channel hold counter runs while in S_HIGH; reaching LONG_CYCLES pulses long_press[i] for one cycle, at most once per press.
  - In toggle mode, a long press also forces stateful_button[i] to 0 on that cycle.
  - The counter resets on leaving S_HIGH.
- Undefined: no port, no hold counter, no long-press effect.

Test Plan:
- Reset: hold rst_n = 0 with button = 4'hF -> all outputs 0. Release rst_n and keep button = 4'hF -> press_pulse = 4'hF for exactly one cycle, 5 edges later.
- Bounce rejection: ch0 toggles every 3 ns (sub-period, clk period 20 ns) for 18 ns, then holds 1 -> exactly one press_pulse[0], and stateful_button[0] goes 0 -> 1.
- Toggle sequence: two clean presses on ch1, each held 8 cycles with 8 cycles low between -> stateful_button[1] goes 1 then 0; two press_pulses and two release_pulses.
- Momentary: mode = 4'b0100, ch2 held 10 cycles -> stateful_button[2] high from the press_pulse cycle until the release_pulse cycle.
- Clear collision: clear = 1 in the same cycle press_pulse[3] fires -> stateful_button[3] = 0 and press_pulse[3] = 1.
- LONG_PRESS_EN with LONG_CYCLES = 50: hold ch0 for 60 cycles -> one long_press[0] pulse 50 cycles after press_pulse[0], and stateful_button[0] = 0.
